// File: rtl/enet_bus_arbiter_if.sv
// Requester port bundle for enet_bus_arbiter.
// One instance per requester. The requester (master) drives the request
// fields and holds them with valid until it sees ready; the arbiter (slave)
// answers with one-cycle ready and done pulses.
//   valid     : access request
//   write     : 1 = data write, 0 = data read
//   index     : DM9000A register index
//   wdata     : write data
//   lock      : keep the grant after this access (sampled at accept)
//   data_only : skip the INDEX phase (honoured only for the lock holder)
//   ready     : request accepted, fields captured
//   done      : access complete
interface enet_bus_arbiter_if;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned DATA_W = 16;

    logic              valid;
    logic              write;
    logic [IDX_W-1:0]  index;
    logic [DATA_W-1:0] wdata;
    logic              lock;
    logic              data_only;
    logic              ready;
    logic              done;

    modport master (
        output valid, write, index, wdata, lock, data_only,
        input  ready, done
    );

    modport slave (
        input  valid, write, index, wdata, lock, data_only,
        output ready, done
    );
endinterface

// File: rtl/enet_bus_arbiter.sv
// DM9000A host-bus owner shared by two requesters.
// req0 is the init/config sequencer, req1 the RX packet reader. Each access
// is an INDEX write (cmd=0) followed by a DATA read/write (cmd=1), each phase
// split into setup/strobe/recovery intervals. Round-robin arbitration with
// a lock so the lock holder can stream data-only (MRCMD) words.
// Optional feature: define ENET_ARB_STATS_EN to enable the per-requester
// saturating grant counters; otherwise stat_grants0/1 read as zero.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   req0, req1           : requester bundles (enet_bus_arbiter_if.slave)
//   rdata                : read data, valid with done, held until next read
//   enet_cs_n/cmd/wr_n/rd_n : DM9000A bus controls
//   enet_data_out/oe     : data pad drive value and enable
//   enet_data_in         : data pad input
//   stat_grants0/1       : accept counters
module enet_bus_arbiter #(
    parameter int unsigned SETUP_CYCLES    = 2,
    parameter int unsigned STROBE_CYCLES   = 3,
    parameter int unsigned RECOVERY_CYCLES = 2
) (
    input  logic                clk,
    input  logic                reset,
    enet_bus_arbiter_if.slave   req0,
    enet_bus_arbiter_if.slave   req1,
    output logic [15:0]         rdata,
    output logic                enet_cs_n,
    output logic                enet_cmd,
    output logic                enet_wr_n,
    output logic                enet_rd_n,
    output logic [15:0]         enet_data_out,
    output logic                enet_data_oe,
    input  logic [15:0]         enet_data_in,
    output logic [15:0]         stat_grants0,
    output logic [15:0]         stat_grants1
);

    localparam int unsigned CNT_W  = 4;
    localparam int unsigned IDX_W  = 8;
    localparam int unsigned DATA_W = 16;

    localparam logic [CNT_W-1:0] SU_LD = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] ST_LD = CNT_W'(STROBE_CYCLES - 1);
    localparam logic [CNT_W-1:0] RC_LD = CNT_W'(RECOVERY_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE, IX_SU, IX_ST, IX_RC, DT_SU, DT_ST, DT_RC
    } state_t;

    typedef struct packed {
        logic              cs_n;
        logic              cmd;
        logic              wr_n;
        logic              rd_n;
        logic              oe;
        logic [DATA_W-1:0] data;
    } bus_t;

    localparam bus_t BUS_IDLE = '{cs_n: 1'b1, cmd: 1'b0, wr_n: 1'b1,
                                  rd_n: 1'b1, oe: 1'b0, data: '0};

    // Bus levels for the state being entered.
    function automatic bus_t bus_drive(input state_t st, input logic wr,
                                       input logic [IDX_W-1:0]  idx,
                                       input logic [DATA_W-1:0] wd);
        bus_t b;
        b = BUS_IDLE;
        case (st)
            IX_SU, IX_ST, IX_RC: begin
                b.cs_n = 1'b0;
                b.oe   = 1'b1;
                b.data = {{(DATA_W-IDX_W){1'b0}}, idx};
                b.wr_n = (st != IX_ST);
            end
            DT_SU, DT_ST, DT_RC: begin
                b.cs_n = 1'b0;
                b.cmd  = 1'b1;
                b.oe   = wr;
                b.data = wr ? wd : '0;
                b.wr_n = !(wr && (st == DT_ST));
                b.rd_n = !(!wr && (st == DT_ST));
            end
            default: b = BUS_IDLE;
        endcase
        return b;
    endfunction

    state_t            state;
    logic [CNT_W-1:0]  cnt;
    bus_t              bus_q;
    logic              rdy0, rdy1, done0, done1;
    logic              cur_sel, cur_write, cur_do;
    logic [IDX_W-1:0]  cur_index;
    logic [DATA_W-1:0] cur_wdata;
    logic              lock_held, holder, ptr;

    logic elig0_c, elig1_c, grant_sel_c, decide_c, accept_c, holder_valid_c;
    logic sel_write_c, sel_lock_c, sel_do_c;
    logic [IDX_W-1:0]  sel_index_c;
    logic [DATA_W-1:0] sel_wdata_c;

    // Arbitration: decided in IDLE, or in the last recovery cycle so a new
    // ready can coincide with the previous done (back-to-back).
    always_comb begin
        elig0_c        = req0.valid && (!lock_held || !holder);
        elig1_c        = req1.valid && (!lock_held ||  holder);
        grant_sel_c    = (elig0_c && elig1_c) ? ptr : elig1_c;
        decide_c       = ((state == IDLE) && !rdy0 && !rdy1) ||
                         ((state == DT_RC) && (cnt == '0));
        accept_c       = decide_c && (elig0_c || elig1_c);
        holder_valid_c = holder ? req1.valid : req0.valid;
        sel_write_c    = grant_sel_c ? req1.write     : req0.write;
        sel_index_c    = grant_sel_c ? req1.index     : req0.index;
        sel_wdata_c    = grant_sel_c ? req1.wdata     : req0.wdata;
        sel_lock_c     = grant_sel_c ? req1.lock      : req0.lock;
        sel_do_c       = grant_sel_c ? req1.data_only : req0.data_only;
    end

    // Access sequencer, arbitration state and registered bus outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            bus_q     <= BUS_IDLE;
            rdy0      <= 1'b0;
            rdy1      <= 1'b0;
            done0     <= 1'b0;
            done1     <= 1'b0;
            rdata     <= '0;
            cur_sel   <= 1'b0;
            cur_write <= 1'b0;
            cur_do    <= 1'b0;
            cur_index <= '0;
            cur_wdata <= '0;
            lock_held <= 1'b0;
            holder    <= 1'b0;
            ptr       <= 1'b0;
        end else begin
            rdy0  <= 1'b0;
            rdy1  <= 1'b0;
            done0 <= 1'b0;
            done1 <= 1'b0;

            // cnt is always zero in IDLE, so IDLE is handled in the case.
            if (cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end else begin
                case (state)
                    IDLE: begin
                        if (rdy0 || rdy1) begin
                            state <= cur_do ? DT_SU : IX_SU;
                            cnt   <= SU_LD;
                            bus_q <= bus_drive(cur_do ? DT_SU : IX_SU,
                                               cur_write, cur_index, cur_wdata);
                        end else if (lock_held && !holder_valid_c) begin
                            lock_held <= 1'b0;
                        end
                    end
                    IX_SU: begin
                        state <= IX_ST;
                        cnt   <= ST_LD;
                        bus_q <= bus_drive(IX_ST, cur_write, cur_index, cur_wdata);
                    end
                    IX_ST: begin
                        state <= IX_RC;
                        cnt   <= RC_LD;
                        bus_q <= bus_drive(IX_RC, cur_write, cur_index, cur_wdata);
                    end
                    IX_RC: begin
                        state <= DT_SU;
                        cnt   <= SU_LD;
                        bus_q <= bus_drive(DT_SU, cur_write, cur_index, cur_wdata);
                    end
                    DT_SU: begin
                        state <= DT_ST;
                        cnt   <= ST_LD;
                        bus_q <= bus_drive(DT_ST, cur_write, cur_index, cur_wdata);
                    end
                    DT_ST: begin
                        if (!cur_write) rdata <= enet_data_in;
                        state <= DT_RC;
                        cnt   <= RC_LD;
                        bus_q <= bus_drive(DT_RC, cur_write, cur_index, cur_wdata);
                    end
                    DT_RC: begin
                        state <= IDLE;
                        bus_q <= BUS_IDLE;
                        done0 <= !cur_sel;
                        done1 <= cur_sel;
                    end
                    default: begin
                        state <= IDLE;
                        bus_q <= BUS_IDLE;
                    end
                endcase
            end

            // data_only is honoured only if this side already held the lock.
            if (accept_c) begin
                rdy0      <= !grant_sel_c;
                rdy1      <= grant_sel_c;
                cur_sel   <= grant_sel_c;
                cur_write <= sel_write_c;
                cur_index <= sel_index_c;
                cur_wdata <= sel_wdata_c;
                cur_do    <= sel_do_c && lock_held && (holder == grant_sel_c);
                lock_held <= sel_lock_c;
                holder    <= grant_sel_c;
                if (elig0_c && elig1_c) ptr <= !ptr;
            end
        end
    end

    assign enet_cs_n     = bus_q.cs_n;
    assign enet_cmd      = bus_q.cmd;
    assign enet_wr_n     = bus_q.wr_n;
    assign enet_rd_n     = bus_q.rd_n;
    assign enet_data_oe  = bus_q.oe;
    assign enet_data_out = bus_q.data;
    assign req0.ready    = rdy0;
    assign req1.ready    = rdy1;
    assign req0.done     = done0;
    assign req1.done     = done1;

`ifdef ENET_ARB_STATS_EN
    // Saturating accept counters.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stat_grants0 <= '0;
            stat_grants1 <= '0;
        end else if (accept_c) begin
            if (!grant_sel_c && (stat_grants0 != 16'hFFFF))
                stat_grants0 <= stat_grants0 + 16'd1;
            if (grant_sel_c && (stat_grants1 != 16'hFFFF))
                stat_grants1 <= stat_grants1 + 16'd1;
        end
    end
`else
    assign stat_grants0 = 16'h0000;
    assign stat_grants1 = 16'h0000;
`endif

endmodule

// File: tb/tb_enet_bus_arbiter.sv
// Directed bench for enet_bus_arbiter: timing, read capture, round-robin,
// lock streaming, mid-access reset and unlocked data_only requests.
module tb_enet_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [15:0] rdata;
    logic        enet_cs_n, enet_cmd, enet_wr_n, enet_rd_n, enet_data_oe;
    logic [15:0] enet_data_out;
    logic [15:0] enet_data_in = 16'hFFFF;
    logic [15:0] stat_grants0, stat_grants1;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_bad = 0;

    enet_bus_arbiter_if r0 ();
    enet_bus_arbiter_if r1 ();

    enet_bus_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .req0         (r0),
        .req1         (r1),
        .rdata        (rdata),
        .enet_cs_n    (enet_cs_n),
        .enet_cmd     (enet_cmd),
        .enet_wr_n    (enet_wr_n),
        .enet_rd_n    (enet_rd_n),
        .enet_data_out(enet_data_out),
        .enet_data_oe (enet_data_oe),
        .enet_data_in (enet_data_in),
        .stat_grants0 (stat_grants0),
        .stat_grants1 (stat_grants1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic idle_reqs();
        r0.valid = 0; r0.write = 0; r0.index = '0; r0.wdata = '0; r0.lock = 0; r0.data_only = 0;
        r1.valid = 0; r1.write = 0; r1.index = '0; r1.wdata = '0; r1.lock = 0; r1.data_only = 0;
    endtask

    task automatic set_req(input int side, input logic wr, input logic [7:0] idx,
                           input logic [15:0] wd, input logic lk, input logic dof);
        if (side == 0) begin
            r0.write = wr; r0.index = idx; r0.wdata = wd; r0.lock = lk; r0.data_only = dof; r0.valid = 1;
        end else begin
            r1.write = wr; r1.index = idx; r1.wdata = wd; r1.lock = lk; r1.data_only = dof; r1.valid = 1;
        end
    endtask

    // Follows one access of a side: records ready/done cycles and strobe activity.
    task automatic watch(input int side, input logic [15:0] rd_val, input int budget,
                         output int rdy_c, output int done_c, output int ix_lo,
                         output int dt_wr_lo, output int rd_lo,
                         output logic [15:0] ix_data, output logic [15:0] dt_data,
                         output logic oe_bad, output logic [15:0] rdata_done, output logic to);
        logic got_rdy, rdy, dn;
        rdy_c = -1; done_c = -1; ix_lo = 0; dt_wr_lo = 0; rd_lo = 0;
        ix_data = 16'hDEAD; dt_data = 16'hDEAD; oe_bad = 0; rdata_done = 16'hDEAD;
        to = 1; got_rdy = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            enet_data_in = (enet_rd_n === 1'b0) ? rd_val : 16'hFFFF;
            if (!enet_cs_n && !enet_cmd && !enet_wr_n) begin
                ix_lo++; ix_data = enet_data_out;
                if (enet_data_oe !== 1'b1) oe_bad = 1;
            end
            if (!enet_cs_n && enet_cmd && !enet_wr_n) begin
                dt_wr_lo++; dt_data = enet_data_out;
                if (enet_data_oe !== 1'b1) oe_bad = 1;
            end
            if (!enet_cs_n && enet_cmd && !enet_rd_n) begin
                rd_lo++;
                if (enet_data_oe !== 1'b0) oe_bad = 1;
            end
            rdy = (side == 0) ? r0.ready : r1.ready;
            dn  = (side == 0) ? r0.done  : r1.done;
            if (got_rdy && dn) begin
                done_c = cyc; rdata_done = rdata; to = 0;
                break;
            end
            if (!got_rdy && rdy) begin
                got_rdy = 1; rdy_c = cyc;
                if (side == 0) r0.valid = 0; else r1.valid = 0;
            end
        end
        enet_data_in = 16'hFFFF;
    endtask

    task automatic test_reset();
        idle_reqs();
        reset = 1;
        repeat (3) @(negedge clk);
        n_cmp++; if (enet_cs_n !== 1'b1) begin n_bad++; $display("FAIL rst_cs_n: got %b want 1", enet_cs_n); end
        n_cmp++; if (enet_wr_n !== 1'b1 || enet_rd_n !== 1'b1) begin n_bad++; $display("FAIL rst_strobes: got wr_n=%b rd_n=%b want 1/1", enet_wr_n, enet_rd_n); end
        n_cmp++; if (enet_cmd !== 1'b0 || enet_data_oe !== 1'b0) begin n_bad++; $display("FAIL rst_cmd_oe: got cmd=%b oe=%b want 0/0", enet_cmd, enet_data_oe); end
        n_cmp++; if (enet_data_out !== 16'h0000) begin n_bad++; $display("FAIL rst_data_out: got %h want 0000", enet_data_out); end
        n_cmp++; if ({r0.ready, r1.ready, r0.done, r1.done} !== 4'b0000) begin n_bad++; $display("FAIL rst_handshake: got %b want 0000", {r0.ready, r1.ready, r0.done, r1.done}); end
        n_cmp++; if (rdata !== 16'h0000) begin n_bad++; $display("FAIL rst_rdata: got %h want 0000", rdata); end
        n_cmp++; if (stat_grants0 !== 16'h0 || stat_grants1 !== 16'h0) begin n_bad++; $display("FAIL rst_stats: got %h/%h want 0/0", stat_grants0, stat_grants1); end
        reset = 0;
        @(negedge clk);
    endtask

    task automatic test_write();
        int rc, dc, ixl, dwl, rdl; logic [15:0] ixd, dtd, rdd; logic oeb, to;
        set_req(0, 1'b1, 8'hFE, 16'h000F, 1'b0, 1'b0);
        watch(0, 16'hFFFF, 40, rc, dc, ixl, dwl, rdl, ixd, dtd, oeb, rdd, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL wr_timeout: got no done want done"); end
        n_cmp++; if (dc - rc !== 15) begin n_bad++; $display("FAIL wr_latency: got %0d want 15", dc - rc); end
        n_cmp++; if (ixl !== 3) begin n_bad++; $display("FAIL wr_ix_strobe: got %0d want 3", ixl); end
        n_cmp++; if (ixd !== 16'h00FE) begin n_bad++; $display("FAIL wr_ix_data: got %h want 00fe", ixd); end
        n_cmp++; if (dwl !== 3) begin n_bad++; $display("FAIL wr_dt_strobe: got %0d want 3", dwl); end
        n_cmp++; if (dtd !== 16'h000F) begin n_bad++; $display("FAIL wr_dt_data: got %h want 000f", dtd); end
        n_cmp++; if (rdl !== 0 || oeb !== 1'b0) begin n_bad++; $display("FAIL wr_rd_oe: got rd_lo=%0d oe_bad=%b want 0/0", rdl, oeb); end
    endtask

    task automatic test_read();
        int rc, dc, ixl, dwl, rdl; logic [15:0] ixd, dtd, rdd; logic oeb, to;
        set_req(1, 1'b0, 8'hF0, 16'h0000, 1'b0, 1'b0);
        watch(1, 16'hA5C3, 40, rc, dc, ixl, dwl, rdl, ixd, dtd, oeb, rdd, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL rd_timeout: got no done want done"); end
        n_cmp++; if (dc - rc !== 15) begin n_bad++; $display("FAIL rd_latency: got %0d want 15", dc - rc); end
        n_cmp++; if (rdl !== 3) begin n_bad++; $display("FAIL rd_strobe: got %0d want 3", rdl); end
        n_cmp++; if (oeb !== 1'b0) begin n_bad++; $display("FAIL rd_oe: got oe_bad=%b want 0", oeb); end
        n_cmp++; if (rdd !== 16'hA5C3) begin n_bad++; $display("FAIL rd_rdata: got %h want a5c3", rdd); end
        n_cmp++; if (ixl !== 3 || ixd !== 16'h00F0) begin n_bad++; $display("FAIL rd_index: got %0d/%h want 3/00f0", ixl, ixd); end
        n_cmp++; if (dwl !== 0) begin n_bad++; $display("FAIL rd_no_wr: got %0d want 0", dwl); end
    endtask

    task automatic test_round_robin();
        int order[6]; int exp_order[6]; int n; logic both, drain, to;
        logic [15:0] exp_stat;
        exp_order = '{0, 1, 0, 1, 0, 1};
        n = 0; both = 0; drain = 0; to = 1;
        reset = 1; @(negedge clk); reset = 0;
        set_req(0, 1'b1, 8'h01, 16'h1111, 1'b0, 1'b0);
        set_req(1, 1'b1, 8'h02, 16'h2222, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (drain && r1.done) begin to = 0; break; end
            if (r0.ready && r1.ready) both = 1;
            if (r0.ready && n < 6) begin order[n] = 0; n++; end
            if (r1.ready && n < 6) begin order[n] = 1; n++; end
            if (n == 6 && !drain) begin drain = 1; r0.valid = 0; r1.valid = 0; end
        end
        n_cmp++; if (to) begin n_bad++; $display("FAIL rr_timeout: got %0d grants want 6 then done", n); end
        n_cmp++; if (both) begin n_bad++; $display("FAIL rr_dual_ready: got 1 want 0"); end
        for (int k = 0; k < 6; k++) begin
            n_cmp++; if (k < n && order[k] !== exp_order[k]) begin n_bad++; $display("FAIL rr_order[%0d]: got req%0d want req%0d", k, order[k], exp_order[k]); end
        end
`ifdef ENET_ARB_STATS_EN
        exp_stat = 16'd3;
`else
        exp_stat = 16'd0;
`endif
        n_cmp++; if (stat_grants0 !== exp_stat || stat_grants1 !== exp_stat) begin n_bad++; $display("FAIL rr_stats: got %0d/%0d want %0d/%0d", stat_grants0, stat_grants1, exp_stat, exp_stat); end
    endtask

    task automatic test_lock();
        int n1, d1, last_rdy1, done1_5, r0_rdy, r0_done, ix_lo;
        int lat[1:5]; logic [15:0] rdv[1:5]; logic to;
        n1 = 0; d1 = 0; last_rdy1 = 0; done1_5 = -1; r0_rdy = -1; r0_done = -1; ix_lo = 0; to = 1;
        for (int k = 1; k <= 5; k++) begin lat[k] = -1; rdv[k] = 16'hDEAD; end
        set_req(1, 1'b0, 8'hF2, 16'h0000, 1'b1, 1'b0);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            enet_data_in = (enet_rd_n === 1'b0) ? (16'hC000 + 16'(n1)) : 16'hFFFF;
            if (!enet_cs_n && !enet_cmd && !enet_wr_n) ix_lo++;
            if (r1.done) begin
                d1++;
                if (d1 <= 5) begin lat[d1] = cyc - last_rdy1; rdv[d1] = rdata; end
                if (d1 == 5) done1_5 = cyc;
            end
            if (r1.ready) begin
                n1++; last_rdy1 = cyc;
                if (n1 == 1) set_req(0, 1'b1, 8'h44, 16'h0044, 1'b0, 1'b0);
                if (n1 < 5) set_req(1, 1'b0, 8'hF2, 16'h0000, (n1 < 4), 1'b1);
                else r1.valid = 0;
            end
            if (r0.ready) begin r0_rdy = cyc; r0.valid = 0; end
            if (r0.done) begin r0_done = cyc; to = 0; break; end
        end
        enet_data_in = 16'hFFFF;
        n_cmp++; if (to) begin n_bad++; $display("FAIL lk_timeout: got no req0 done want done"); end
        n_cmp++; if (d1 !== 5) begin n_bad++; $display("FAIL lk_count: got %0d want 5", d1); end
        n_cmp++; if (lat[1] !== 15) begin n_bad++; $display("FAIL lk_first_latency: got %0d want 15", lat[1]); end
        for (int k = 2; k <= 5; k++) begin
            n_cmp++; if (lat[k] !== 8) begin n_bad++; $display("FAIL lk_latency[%0d]: got %0d want 8", k, lat[k]); end
        end
        for (int k = 1; k <= 5; k++) begin
            n_cmp++; if (rdv[k] !== 16'hC000 + 16'(k)) begin n_bad++; $display("FAIL lk_rdata[%0d]: got %h want %h", k, rdv[k], 16'hC000 + 16'(k)); end
        end
        n_cmp++; if (r0_rdy !== done1_5) begin n_bad++; $display("FAIL lk_req0_grant: got cycle %0d want %0d", r0_rdy, done1_5); end
        n_cmp++; if (r0_done - r0_rdy !== 15) begin n_bad++; $display("FAIL lk_req0_latency: got %0d want 15", r0_done - r0_rdy); end
        n_cmp++; if (ix_lo !== 6) begin n_bad++; $display("FAIL lk_index_phases: got %0d strobe cycles want 6", ix_lo); end
    endtask

    task automatic test_reset_mid();
        logic found, to; int rc, dc;
        found = 0; to = 1; rc = -1; dc = -1;
        set_req(0, 1'b1, 8'h22, 16'hBEEF, 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (r0.ready) r0.valid = 0;
            if (!enet_wr_n && enet_cmd) begin found = 1; break; end
        end
        n_cmp++; if (!found) begin n_bad++; $display("FAIL mr_reach_dt_st: got none want data strobe"); end
        set_req(0, 1'b1, 8'h55, 16'h5555, 1'b0, 1'b0);
        set_req(1, 1'b0, 8'h66, 16'h0000, 1'b0, 1'b0);
        reset = 1;
        #1;
        n_cmp++; if (enet_cs_n !== 1'b1 || enet_wr_n !== 1'b1 || enet_rd_n !== 1'b1) begin n_bad++; $display("FAIL mr_bus_idle: got cs_n=%b wr_n=%b rd_n=%b want 1/1/1", enet_cs_n, enet_wr_n, enet_rd_n); end
        n_cmp++; if (enet_data_oe !== 1'b0 || enet_cmd !== 1'b0) begin n_bad++; $display("FAIL mr_oe_cmd: got oe=%b cmd=%b want 0/0", enet_data_oe, enet_cmd); end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_cmp++; if (r0.done !== 1'b0) begin n_bad++; $display("FAIL mr_no_done: got %b want 0", r0.done); end
        end
        reset = 0;
        @(negedge clk);
        n_cmp++; if (r0.ready !== 1'b1 || r1.ready !== 1'b0) begin n_bad++; $display("FAIL mr_first_grant: got r0=%b r1=%b want 1/0", r0.ready, r1.ready); end
        rc = cyc;
        r0.valid = 0; r1.valid = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (r0.done) begin dc = cyc; to = 0; break; end
        end
        n_cmp++; if (to || dc - rc !== 15) begin n_bad++; $display("FAIL mr_after_latency: got %0d want 15", dc - rc); end
    endtask

    task automatic test_data_only_nolock();
        int rc, dc, ixl, dwl, rdl; logic [15:0] ixd, dtd, rdd; logic oeb, to;
        set_req(0, 1'b1, 8'h33, 16'h5A5A, 1'b0, 1'b1);
        watch(0, 16'hFFFF, 40, rc, dc, ixl, dwl, rdl, ixd, dtd, oeb, rdd, to);
        n_cmp++; if (to) begin n_bad++; $display("FAIL do_timeout: got no done want done"); end
        n_cmp++; if (dc - rc !== 15) begin n_bad++; $display("FAIL do_latency: got %0d want 15", dc - rc); end
        n_cmp++; if (ixl !== 3 || ixd !== 16'h0033) begin n_bad++; $display("FAIL do_index: got %0d/%h want 3/0033", ixl, ixd); end
        n_cmp++; if (dwl !== 3 || dtd !== 16'h5A5A) begin n_bad++; $display("FAIL do_data: got %0d/%h want 3/5a5a", dwl, dtd); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_write();
        test_read();
        test_round_robin();
        test_lock();
        test_reset_mid();
        test_data_only_nolock();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
